// File: rtl/rect_plot_arbiter_pkg.sv
// rect_plot_pkg: shared FSM state type and screen/pixel geometry for the rectangle plot arbiter
package rect_plot_pkg;
    typedef enum logic [1:0] {IDLE, LATCH, DRAW, DONE} state_t;
    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;
    localparam int X_W      = 8;
    localparam int Y_W      = 7;
    localparam int COLOUR_W = 3;
endpackage

// File: rtl/rect_plot_arbiter_if.sv
// rect_plot_if: requester rectangles/grants and the single VGA adapter plot port
interface rect_plot_if #(parameter int NUM_REQ = 4) ();
    import rect_plot_pkg::*;
    logic [NUM_REQ-1:0]          req;
    logic [NUM_REQ*X_W-1:0]      rect_x;
    logic [NUM_REQ*Y_W-1:0]      rect_y;
    logic [NUM_REQ*X_W-1:0]      rect_w;
    logic [NUM_REQ*Y_W-1:0]      rect_h;
    logic [NUM_REQ*COLOUR_W-1:0] rect_colour;
    logic [NUM_REQ-1:0]          grant;
    logic [NUM_REQ-1:0]          done;
    logic [X_W-1:0]              x;
    logic [Y_W-1:0]              y;
    logic [COLOUR_W-1:0]         colour;
    logic                        plot;
    logic                        busy;
    modport slave (
        input  req, rect_x, rect_y, rect_w, rect_h, rect_colour,
        output grant, done, x, y, colour, plot, busy
    );
    modport master (
        output req, rect_x, rect_y, rect_w, rect_h, rect_colour,
        input  grant, done, x, y, colour, plot, busy
    );
endinterface

// File: rtl/rect_plot_arbiter_rr_pick.sv
// rr_pick: round-robin selector, first set request at or above ptr with wraparound
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [PTR_W-1:0]   sel,
    output logic               valid
);
    int idx;
    // scan from the farthest offset down so the closest set bit to ptr wins
    always_comb begin
        sel = '0;
        idx = 0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            idx = (int'(ptr) + i) % NUM_REQ;
            if (req[idx]) sel = PTR_W'(idx);
        end
    end
    assign valid = |req;
endmodule

// File: rtl/rect_plot_arbiter.sv
// rect_plot_arbiter: round-robin rectangle rasteriser sharing one adapter plot port; RECT_PLOT_CLIP_EN masks off-screen pixels
module rect_plot_arbiter
    import rect_plot_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic       clock,
    input  logic       reset_n,
    rect_plot_if.slave bus
);
    state_t               state, next_state;
    logic [PTR_W-1:0]     ptr, own, pick;
    logic                 pick_valid;
    logic [X_W-1:0]       ox, w, col, in_x, in_w, px;
    logic [Y_W-1:0]       oy, h, row, in_y, in_h, py;
    logic [COLOUR_W-1:0]  colour_q, in_colour;
    logic                 col_last, row_last, on_screen, drawing;

    rr_pick #(.NUM_REQ(NUM_REQ), .PTR_W(PTR_W)) u_pick (
        .req  (bus.req),
        .ptr  (ptr),
        .sel  (pick),
        .valid(pick_valid)
    );

    assign in_x      = bus.rect_x[int'(own)*X_W +: X_W];
    assign in_y      = bus.rect_y[int'(own)*Y_W +: Y_W];
    assign in_w      = bus.rect_w[int'(own)*X_W +: X_W];
    assign in_h      = bus.rect_h[int'(own)*Y_W +: Y_W];
    assign in_colour = bus.rect_colour[int'(own)*COLOUR_W +: COLOUR_W];
    assign col_last  = col == w - X_W'(1);
    assign row_last  = row == h - Y_W'(1);

`ifdef RECT_PLOT_CLIP_EN
    logic [X_W:0] xs;
    logic [Y_W:0] ys;
    assign xs        = {1'b0, ox} + {1'b0, col};
    assign ys        = {1'b0, oy} + {1'b0, row};
    assign px        = xs[X_W-1:0];
    assign py        = ys[Y_W-1:0];
    assign on_screen = xs < (X_W+1)'(SCREEN_W) && ys < (Y_W+1)'(SCREEN_H);
`else
    assign px        = ox + col;
    assign py        = oy + row;
    assign on_screen = 1'b1;
`endif

    // state register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= next_state;
    end

    // next-state decode and adapter/requester outputs
    always_comb begin
        next_state = state;
        case (state)
            IDLE:  next_state = pick_valid ? LATCH : IDLE;
            LATCH: next_state = (in_w == '0 || in_h == '0) ? DONE : DRAW;
            DRAW:  next_state = (col_last && row_last) ? DONE : DRAW;
            DONE:  next_state = IDLE;
        endcase
        drawing    = state == DRAW;
        bus.grant  = state != IDLE ? NUM_REQ'(1) << own : '0;
        bus.done   = state == DONE ? NUM_REQ'(1) << own : '0;
        bus.x      = drawing ? px : '0;
        bus.y      = drawing ? py : '0;
        bus.colour = drawing ? colour_q : '0;
        bus.plot   = drawing && on_screen;
        bus.busy   = state != IDLE;
    end

    // owner, pointer, latched rectangle and raster counters
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            {ptr, own, ox, oy, w, h, colour_q, col, row} <= '0;
        end else begin
            case (state)
                IDLE:  if (pick_valid) own <= pick;
                LATCH: begin
                    ox       <= in_x;
                    oy       <= in_y;
                    w        <= in_w;
                    h        <= in_h;
                    colour_q <= in_colour;
                    col      <= '0;
                    row      <= '0;
                end
                DRAW:  begin
                    col <= col_last ? '0 : col + X_W'(1);
                    row <= col_last ? row + Y_W'(1) : row;
                end
                DONE:  ptr <= own == PTR_W'(NUM_REQ - 1) ? '0 : own + PTR_W'(1);
            endcase
        end
    end
endmodule

// File: tb/tb_rect_plot_arbiter.sv
// tb_rect_plot_arbiter: scoreboard bench for rect_plot_arbiter (honours RECT_PLOT_CLIP_EN when defined)
module tb_rect_plot_arbiter;
    typedef struct packed {
        logic       is_done;
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] c;
        logic [3:0] d;
    } item_t;

    logic  clock = 1'b0;
    logic  reset_n;
    int    tests = 0;
    int    fails = 0;
    item_t sb[$];
    item_t act, exp_item;

    rect_plot_if #(.NUM_REQ(4)) bus ();

    rect_plot_arbiter #(.NUM_REQ(4)) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .bus    (bus.slave)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] a, input logic [31:0] e);
        tests++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, a, e);
        end
    endtask

    task automatic set_rect(input int i, input int rx, input int ry, input int rw, input int rh, input int rc);
        bus.rect_x[i*8 +: 8]      = 8'(rx);
        bus.rect_y[i*7 +: 7]      = 7'(ry);
        bus.rect_w[i*8 +: 8]      = 8'(rw);
        bus.rect_h[i*7 +: 7]      = 7'(rh);
        bus.rect_colour[i*3 +: 3] = 3'(rc);
    endtask

    task automatic push_rect(input int i, input int rx, input int ry, input int rw, input int rh, input int rc, input int limit);
        item_t e;
        int    n = 0;
        for (int r = 0; r < rh; r++)
            for (int cl = 0; cl < rw; cl++) begin
                if (n < limit) begin
                    e = '0;
                    e.x = 8'(rx + cl);
                    e.y = 7'(ry + r);
                    e.c = 3'(rc);
`ifdef RECT_PLOT_CLIP_EN
                    if (rx + cl < 160 && ry + r < 120) sb.push_back(e);
`else
                    sb.push_back(e);
`endif
                end
                n++;
            end
        if (limit >= rw * rh) begin
            e = '0;
            e.is_done = 1'b1;
            e.d = 4'(1 << i);
            sb.push_back(e);
        end
    endtask

    task automatic run_grant(input int idx, input int exp_cyc, input int start, input string name);
        int cyc  = start;
        bit seen = 1'b0;
        while (!seen && cyc < exp_cyc + 20) begin
            @(negedge clock);
            cyc++;
            if (cyc == 2) begin
                check({name, "_grant"}, 32'(bus.grant), 32'(1 << idx));
                check({name, "_busy"}, 32'(bus.busy), 32'd1);
            end
            if (bus.done[idx]) begin
                seen = 1'b1;
                bus.req[idx] = 1'b0;
            end
        end
        check({name, "_cycles"}, 32'(cyc), 32'(exp_cyc));
    endtask

    task automatic align();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        repeat (2) @(posedge clock);
        #1 reset_n = 1'b1;
    endtask

    task automatic check_zero(input string name);
        check({name, "_grant"}, 32'(bus.grant), 32'd0);
        check({name, "_done"}, 32'(bus.done), 32'd0);
        check({name, "_x"}, 32'(bus.x), 32'd0);
        check({name, "_y"}, 32'(bus.y), 32'd0);
        check({name, "_colour"}, 32'(bus.colour), 32'd0);
        check({name, "_plot"}, 32'(bus.plot), 32'd0);
        check({name, "_busy"}, 32'(bus.busy), 32'd0);
    endtask

    // monitor: every plot or done the DUT presents must match the head of the scoreboard
    initial begin
        forever begin
            @(negedge clock);
            if (reset_n && (bus.plot || bus.done != 0)) begin
                act = '0;
                act.is_done = |bus.done;
                act.x = bus.x;
                act.y = bus.y;
                act.c = bus.colour;
                act.d = bus.done;
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_output: got %0h expected nothing", act);
                end else begin
                    exp_item = sb.pop_front();
                    check("sb_item", 32'(act), 32'(exp_item));
                end
            end
        end
    end

    initial begin
        reset_n = 1'b0;
        bus.req = '0;
        bus.rect_x = '0;
        bus.rect_y = '0;
        bus.rect_w = '0;
        bus.rect_h = '0;
        bus.rect_colour = '0;
        repeat (3) @(negedge clock);
        check_zero("reset");
        align();
        reset_n = 1'b1;

        set_rect(0, 60, 40, 40, 5, 3'b100);
        push_rect(0, 60, 40, 40, 5, 3'b100, 100000);
        bus.req[0] = 1'b1;
        run_grant(0, 203, 0, "t1");
        @(negedge clock);
        check("t1_idle_busy", 32'(bus.busy), 32'd0);
        check("t1_idle_grant", 32'(bus.grant), 32'd0);

        do_reset();
        set_rect(0, 0, 0, 2, 1, 3'b001);
        set_rect(2, 10, 10, 1, 2, 3'b010);
        push_rect(0, 0, 0, 2, 1, 3'b001, 100000);
        push_rect(2, 10, 10, 1, 2, 3'b010, 100000);
        bus.req = 4'b0101;
        run_grant(0, 5, 0, "t2a");
        run_grant(2, 5, 0, "t2b");

        align();
        set_rect(3, 20, 20, 1, 1, 3'b111);
        push_rect(3, 20, 20, 1, 1, 3'b111, 100000);
        push_rect(0, 0, 0, 2, 1, 3'b001, 100000);
        bus.req = 4'b1001;
        run_grant(3, 4, 0, "t2c");
        run_grant(0, 5, 0, "t2d");

        align();
        set_rect(1, 30, 30, 0, 7, 3'b101);
        push_rect(1, 30, 30, 0, 7, 3'b101, 100000);
        bus.req[1] = 1'b1;
        run_grant(1, 3, 0, "t3");

        align();
        set_rect(0, 60, 40, 40, 5, 3'b100);
        push_rect(0, 60, 40, 40, 5, 3'b100, 50);
        bus.req[0] = 1'b1;
        repeat (52) @(negedge clock);
        #1 reset_n = 1'b0;
        #1 check_zero("t4_abort");
        check("t4_sb_drained", 32'(sb.size()), 32'd0);
        repeat (2) @(posedge clock);
        push_rect(0, 60, 40, 40, 5, 3'b100, 100000);
        #1 reset_n = 1'b1;
        run_grant(0, 203, 0, "t4");

        align();
        set_rect(2, 150, 0, 20, 1, 3'b011);
        push_rect(2, 150, 0, 20, 1, 3'b011, 100000);
        bus.req[2] = 1'b1;
        run_grant(2, 23, 0, "t5");

        align();
        set_rect(3, 5, 6, 4, 3, 3'b110);
        push_rect(3, 5, 6, 4, 3, 3'b110, 100000);
        bus.req[3] = 1'b1;
        repeat (6) @(negedge clock);
        set_rect(3, 100, 100, 9, 9, 3'b001);
        bus.req[3] = 1'b0;
        run_grant(3, 15, 6, "t6");

        repeat (4) @(negedge clock);
        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
